// File: rtl/cmp_vec_sequencer.sv
// Stimulus/response sequencer for the 4x4-bit compare DUT: one vector per clock, y folded into a MISR.
// Define CMP_SEQ_LFSR_STIM_EN to take stimulus from a 16-bit LFSR instead of a counter.
module cmp_vec_sequencer #(
  parameter int unsigned NVEC      = 65536,
  parameter logic [31:0] MISR_POLY = 32'h04C11DB7,
  parameter logic [31:0] MISR_SEED = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  a0,
  output logic [3:0]  a1,
  output logic [3:0]  a2,
  output logic [3:0]  a3,
  input  logic [44:0] y,
  output logic        busy,
  output logic        done,
  output logic [16:0] vec_cnt,
  output logic [31:0] sig
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [16:0] LAST_IDX = 17'(NVEC - 1);

  state_t      state_r;
  state_t      state_s;
  logic [16:0] vec_cnt_s;
  logic [31:0] sig_s;
  logic [15:0] stim_s;
  logic        busy_s;
  logic        done_s;

  // Upper 13 result bits are folded onto the low word before the shift step.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [44:0] r);
    logic [31:0] f;
    f = r[31:0] ^ {19'd0, r[44:32]};
    return ({s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'd0)) ^ f;
  endfunction

`ifdef CMP_SEQ_LFSR_STIM_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_r;
  logic [15:0] lfsr_s;

  // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
`endif

  // Next-state, datapath and output selection.
  always_comb begin
    state_s   = state_r;
    vec_cnt_s = vec_cnt;
    sig_s     = sig;
    stim_s    = {a3, a2, a1, a0};
    busy_s    = busy;
    done_s    = done;
`ifdef CMP_SEQ_LFSR_STIM_EN
    lfsr_s    = lfsr_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s   = RUN;
          vec_cnt_s = 17'd0;
          sig_s     = MISR_SEED;
          busy_s    = 1'b1;
          done_s    = 1'b0;
`ifdef CMP_SEQ_LFSR_STIM_EN
          lfsr_s    = LFSR_SEED;
          stim_s    = LFSR_SEED;
`else
          stim_s    = 16'd0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        sig_s     = misr_step(sig, y);
        vec_cnt_s = vec_cnt + 17'd1;
        if (vec_cnt == LAST_IDX) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          stim_s  = 16'd0;
        end else begin
`ifdef CMP_SEQ_LFSR_STIM_EN
          lfsr_s = lfsr_next(lfsr_r);
          stim_s = lfsr_next(lfsr_r);
`else
          stim_s = vec_cnt[15:0] + 16'd1;
`endif
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        stim_s  = 16'd0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      a0      <= 4'd0;
      a1      <= 4'd0;
      a2      <= 4'd0;
      a3      <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vec_cnt <= 17'd0;
      sig     <= MISR_SEED;
    end else begin
      state_r            <= state_s;
      {a3, a2, a1, a0}   <= stim_s;
      busy               <= busy_s;
      done               <= done_s;
      vec_cnt            <= vec_cnt_s;
      sig                <= sig_s;
    end
  end

`ifdef CMP_SEQ_LFSR_STIM_EN
  // Stimulus generator state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_s;
    end
  end
`endif

endmodule
